// File: rtl/calc_display_pkg.sv
// Shared types and constants for the calculator result display.
// FSM state encoding, active-low 7-segment glyphs and display digit positions.
package calc_display_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t UPDATE = 2'd2;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [1:0] DIG_ONES     = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [1:0] DIG_SIGN     = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment glyph; values above 9 are blank.
module seg7_decode
  import calc_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    if (bcd <= 4'd9) seg = GLYPH_DIGIT[bcd];
  end

endmodule

// File: rtl/result_display.sv
// Two's-complement result -> sign-magnitude -> 3-digit BCD (sequential double-dabble),
// shown on a 4-digit multiplexed 7-segment display. Define LEADING_ZERO_BLANK_EN to blank
// leading zeros of the hundreds and tens digits.
module result_display
  import calc_display_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] twos,
  input  logic         load,
  output logic         busy,
  output logic         done,
  output logic [6:0]   seg,
  output logic [3:0]   an
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic [N-1:0]   mag_q, mag_d;
  logic [11:0]    bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           disp_sign_q;
  logic [11:0]    disp_bcd_q;
  logic [SW-1:0]  scan_q;
  logic [1:0]     idx_q;
  logic [3:0]     nib;
  logic           blank;
  logic [6:0]     dec_seg, seg_d, seg_q;
  logic [3:0]     an_d, an_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 3; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          sign_d  = twos[N-1];
          // Bit N of the widened magnitude is always zero, so N bits hold 2^(N-1) exactly
          mag_d   = twos[N-1] ? (~twos + 1'b1) : twos;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == UPDATE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      disp_sign_q <= 1'b0;
      disp_bcd_q  <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      if (state_q == UPDATE) begin
        disp_sign_q <= sign_q;
        disp_bcd_q  <= bcd_q;
      end
    end
  end

  always_comb begin
    nib   = disp_bcd_q[3:0];
    blank = 1'b0;
    unique case (idx_q)
      DIG_ONES: nib = disp_bcd_q[3:0];
      DIG_TENS: begin
        nib = disp_bcd_q[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (disp_bcd_q[11:8] == 4'd0) && (disp_bcd_q[7:4] == 4'd0);
`endif
      end
      DIG_HUNDREDS: begin
        nib = disp_bcd_q[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (disp_bcd_q[11:8] == 4'd0);
`endif
      end
      DIG_SIGN: nib = 4'hf;
    endcase
  end

  seg7_decode u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

  always_comb begin
    if (idx_q == DIG_SIGN) seg_d = disp_sign_q ? GLYPH_MINUS : GLYPH_BLANK;
    else if (blank)        seg_d = GLYPH_BLANK;
    else                   seg_d = dec_seg;
    an_d = ~(4'b0001 << idx_q);
  end

  // an and seg share one register stage so a digit never shows its neighbour's glyph
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q <= '0;
      idx_q  <= DIG_ONES;
      an_q   <= 4'b1111;
      seg_q  <= GLYPH_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      if (scan_q == SW'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display with a fast scan divider.
module tb_result_display;

  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [6:0] GM = 7'b0111111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = GB;
`else
  localparam logic [6:0] Z = G0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] twos = 8'h00;
  logic       load = 1'b0;
  logic       busy, done;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  result_display #(.N(8), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .twos  (twos),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_digit(input int idx, output logic [6:0] s);
    logic [3:0] want;
    logic       found;
    want  = ~(4'b0001 << idx);
    found = 1'b0;
    s     = GB;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == want) begin
        found = 1'b1;
        s     = seg;
      end
    end
    if (!found) check("scan_timeout", 32'(an), 32'(want));
  endtask

  task automatic show(input string tag, input logic [6:0] es, input logic [6:0] eh,
                      input logic [6:0] et, input logic [6:0] eo);
    logic [6:0] s;
    read_digit(3, s); check({tag, "_sign"}, 32'(s), 32'(es));
    read_digit(2, s); check({tag, "_hund"}, 32'(s), 32'(eh));
    read_digit(1, s); check({tag, "_tens"}, 32'(s), 32'(et));
    read_digit(0, s); check({tag, "_ones"}, 32'(s), 32'(eo));
  endtask

  task automatic convert(input string tag, input logic [7:0] v);
    int cyc;
    @(negedge clk);
    load = 1'b1;
    twos = v;
    @(negedge clk);
    load = 1'b0;
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'd9);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  logic [3:0] exp_an [4];
  int         ndone;

  initial begin
    exp_an = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset and scan
    #12;
    check("rst_an", 32'(an), 32'hf);
    check("rst_seg", 32'(seg), 32'(GB));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("scan_an0", 32'(an), 32'hE);
    check("scan_ones0", 32'(seg), 32'(G0));
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      check($sformatf("scan_an_step%0d", k + 1), 32'(an), 32'(exp_an[k]));
      if (k == 2) check("scan_sign_blank", 32'(seg), 32'(GB));
    end

    convert("p2a", 8'h2A);
    show("p2a", GB, Z, G4, G2);

    convert("nd6", 8'hD6);
    show("nd6", GM, Z, G4, G2);

    convert("n80", 8'h80);
    show("n80", GM, G1, G2, G8);

    convert("p7f", 8'h7F);
    show("p7f", GB, G1, G2, G7);

    convert("nff", 8'hFF);
    show("nff", GM, Z, Z, G1);

    // Load while busy is ignored
    @(negedge clk);
    load = 1'b1;
    twos = 8'h05;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    load = 1'b1;
    twos = 8'h63;
    ndone = 0;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_load_dones", 32'(ndone), 32'd1);
    show("busy_load", GB, Z, Z, G5);

    // Reset mid-conversion
    @(negedge clk);
    load = 1'b1;
    twos = 8'h7F;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_an", 32'(an), 32'hf);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    show("midrst", GB, Z, Z, G0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
Output side of the two-function calculator. Takes an 8-bit two's-complement result and converts it to sign-magnitude, then to 3-digit BCD using a sequential double-dabble. It drives a 4-digit multiplexed 7-segment display showing a sign digit plus hundreds, tens and ones. It sits after the ALU, mirroring the keypad → BCD → sign-magnitude → two's-complement input path.

Parameters:
- N, 8, width of the two's-complement input; BCD covers 3 digits (max magnitude 128).
- SCAN_DIV, 50000, clk cycles each digit stays enabled (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- twos  input  N  two's-complement value to display
- load  input  1  one-cycle strobe; captures twos when idle
- busy  output  1  high while a conversion is running
- done  output  1  one-cycle pulse when the display registers update
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- an  output  4  digit enables, active-low; an[3] is the sign digit, an[0] is the ones digit

Behaviour:
- Reset (reset=0, async): FSM=IDLE; busy=0; done=0; sign=0; displayed BCD=000; scan counter=0; digit index=0; an=4'b1111; seg=7'b1111111.
  - After release, scanning resumes and shows value 0.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE, load=1:
  - Capture sign=twos[N-1] and mag = sign ? -twos : twos, computed N+1 bits wide so that 8'h80 → 128.
  - Clear the BCD accumulator and enter SHIFT; busy=1 from the next cycle.
- SHIFT, N cycles:
  - Each cycle, first add 3 to every BCD nibble ≥5, then shift {bcd,mag} left by 1.
  - A bit counter counts 0..N-1; at N-1, go to UPDATE.
- UPDATE, 1 cycle:
  - Copy sign and BCD into the display registers; done=1; busy=0 in the following cycle; return to IDLE.
- Latency: load in cycle 0 → done high in cycle N+1 (9 for N=8) → new digits visible from cycle N+2.
- load while busy: ignored, no queuing. A load coinciding with UPDATE is also ignored.
- Display registers change only in UPDATE; the digits shown are never partial.
- Scan:
  - The free-running counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→3→0.
  - an is the one-cold pattern of the index; seg is registered with an, so there is no ghosting.
- Digit 3 shows '-' (7'b0111111) if sign=1, else blank (7'b1111111).
- Digits 2..0 show BCD glyphs; nibble values >9 show blank.
- Reset mid-conversion: aborts immediately, back to the reset state.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined:
  - Hundreds digit is blank when 0.
  - Tens digit is blank when hundreds=0 and tens=0.
  - Ones digit is always shown.
  - -5 displays as "-  5".
- Undefined: all three digits are always shown; -5 displays as "-005".

Decomposition:
- Package calc_display_pkg:
  - FSM state enum (IDLE, SHIFT, UPDATE).
  - Glyph constants GLYPH_BLANK, GLYPH_MINUS, GLYPH_DIGIT[0:9] (active-low).
  - Digit index constants.
- One sub-module, seg7_decode: combinational 4-bit BCD → 7-bit active-low glyph, blank for values >9.

Test Plan:
1. Reset and scan, SCAN_DIV=4: assert reset=0 → an=1111, seg=1111111, busy=0. Release → an cycles 1110, 1101, 1011, 0111, 1110 every 4 clks; the ones digit shows '0' (7'b1000000).
2. Positive value: load with twos=8'h2A → busy for cycles 1..8, done at cycle 9. Then an=1110 shows '2' (7'b0100100), an=1101 shows '4' (7'b0011001), sign digit blank. Hundreds is blank with LEADING_ZERO_BLANK_EN, '0' without.
3. Negative value: twos=8'hD6 (-42) → sign digit 7'b0111111, tens '4', ones '2'.
4. Extremes:
   - twos=8'h80 → '-', '1', '2', '8'.
   - twos=8'h7F → blank, '1', '2', '7'.
   - twos=8'hFF → '-', ones '1'.
5. Load while busy: load twos=8'h05, then load twos=8'h63 at cycle 3 → one done only, display shows 5; the second load is ignored.
6. Reset mid-conversion: reset=0 at cycle 4 of SHIFT → busy=0 immediately, no done pulse, display returns to 0 after release.
